// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, picks the next PC from redirect/stall/
// predicted-taken/sequential sources, and holds the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             jumpSuccess,
    input  logic [31:0]      correctPc,
    input  logic             mux1select,
    input  logic [31:0]      BpctoID,
    output logic [31:0]      imemAddr,
    input  logic [31:0]      imemData,
    output logic [31:0]      insttoID,
    output logic [31:0]      pcNewtoID,
    output logic             validtoID,
    output logic [CNT_W-1:0] flushCount
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_new;
        logic        valid;
    } ifid_t;

    localparam ifid_t BUBBLE = '{inst: NOP, pc_new: 32'h0, valid: 1'b0};

    logic [31:0]      pc_q, pc_d;
    ifid_t            ifid_q, ifid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        cnt_d  = cnt_q;
        if (jumpSuccess) begin
            // mispredict outranks everything, including a stalled ID branch
            pc_d   = correctPc & ~32'h3;
            ifid_d = BUBBLE;
            if (cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + 1'b1;
        end else if (stall) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
        end else if (mux1select) begin
            // squash the sequential wrong-path fetch made this cycle
            pc_d   = BpctoID & ~32'h3;
            ifid_d = BUBBLE;
        end else begin
            pc_d   = pc_plus4;
            ifid_d = '{inst: imemData, pc_new: pc_plus4, valid: 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC & ~32'h3;
            ifid_q <= BUBBLE;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign imemAddr   = pc_q;
    assign insttoID   = ifid_q.inst;
    assign pcNewtoID  = ifid_q.pc_new;
    assign validtoID  = ifid_q.valid;
    assign flushCount = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns addr+0x100.
module tb_fetch_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stall = 1'b0;
    logic             jumpSuccess = 1'b0;
    logic [31:0]      correctPc = '0;
    logic             mux1select = 1'b0;
    logic [31:0]      BpctoID = '0;
    logic [31:0]      imemAddr;
    logic [31:0]      imemData;
    logic [31:0]      insttoID;
    logic [31:0]      pcNewtoID;
    logic             validtoID;
    logic [CNT_W-1:0] flushCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imemData = imemAddr + 32'h100;

    fetch_unit #(.RESET_PC(32'h0), .NOP(32'h0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .jumpSuccess(jumpSuccess),
        .correctPc(correctPc), .mux1select(mux1select), .BpctoID(BpctoID),
        .imemAddr(imemAddr), .imemData(imemData), .insttoID(insttoID),
        .pcNewtoID(pcNewtoID), .validtoID(validtoID), .flushCount(flushCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                           input logic [31:0] pcn, input logic vld);
        chk({tag, ".addr"}, imemAddr, addr);
        chk({tag, ".inst"}, insttoID, inst);
        chk({tag, ".pcnew"}, pcNewtoID, pcn);
        chk({tag, ".valid"}, {31'b0, validtoID}, {31'b0, vld});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        #2;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("reset.cnt", {28'b0, flushCount}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // free run from RESET_PC
        tick(); chk_all("run0", 32'h4, 32'h100, 32'h4, 1'b1);
        tick(); chk_all("run1", 32'h8, 32'h104, 32'h8, 1'b1);
        tick(); chk_all("run2", 32'hC, 32'h108, 32'hC, 1'b1);
        tick(); chk_all("run3", 32'h10, 32'h10C, 32'h10, 1'b1);

        // ID predicted-taken redirect
        mux1select = 1'b1; BpctoID = 32'h40;
        tick(); chk_all("pred", 32'h40, 32'h0, 32'h0, 1'b0);
        chk("pred.cnt", {28'b0, flushCount}, 32'h0);
        mux1select = 1'b0;
        tick(); chk_all("pred_tgt", 32'h44, 32'h140, 32'h44, 1'b1);

        // mispredict beats stall and mux1select, low bits masked
        mux1select = 1'b1; BpctoID = 32'h20;
        tick(); chk("to20.addr", imemAddr, 32'h20);
        jumpSuccess = 1'b1; correctPc = 32'h83; mux1select = 1'b1; BpctoID = 32'h50; stall = 1'b1;
        tick(); chk_all("misp", 32'h80, 32'h0, 32'h0, 1'b0);
        chk("misp.cnt", {28'b0, flushCount}, 32'h1);
        jumpSuccess = 1'b0; mux1select = 1'b0; stall = 1'b0;
        tick(); chk_all("misp_tgt", 32'h84, 32'h180, 32'h84, 1'b1);

        // stall 3 cycles at pc=0x30 (mux1select ignored while stalled)
        mux1select = 1'b1; BpctoID = 32'h2D;
        tick(); chk("to2c.addr", imemAddr, 32'h2C);
        mux1select = 1'b0;
        tick(); chk_all("pre_stall", 32'h30, 32'h12C, 32'h30, 1'b1);
        stall = 1'b1;
        tick(); chk_all("stall0", 32'h30, 32'h12C, 32'h30, 1'b1);
        mux1select = 1'b1; BpctoID = 32'h90;
        tick(); chk_all("stall1", 32'h30, 32'h12C, 32'h30, 1'b1);
        mux1select = 1'b0;
        tick(); chk_all("stall2", 32'h30, 32'h12C, 32'h30, 1'b1);
        stall = 1'b0;
        tick(); chk_all("resume", 32'h34, 32'h130, 32'h34, 1'b1);

        // wrap at top of address space
        jumpSuccess = 1'b1; correctPc = 32'hFFFF_FFFE;
        tick(); chk("wrap_tgt.addr", imemAddr, 32'hFFFF_FFFC);
        chk("wrap.cnt", {28'b0, flushCount}, 32'h2);
        jumpSuccess = 1'b0;
        tick(); chk_all("wrap0", 32'h0, 32'h0000_00FC, 32'h0, 1'b1);
        tick(); chk_all("wrap1", 32'h4, 32'h100, 32'h4, 1'b1);

        // back-to-back mispredicts saturate the counter at 0xF
        exp_cnt = 2;
        jumpSuccess = 1'b1;
        for (int i = 0; i < 17; i++) begin
            correctPc = 32'h200 + 32'(4 * i);
            tick();
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            chk($sformatf("b2b%0d.cnt", i), {28'b0, flushCount}, 32'(exp_cnt));
            chk($sformatf("b2b%0d.addr", i), imemAddr, 32'h200 + 32'(4 * i));
        end
        chk("sat.cnt", {28'b0, flushCount}, 32'hF);
        jumpSuccess = 1'b0;

        // asynchronous reset mid-stall
        tick(); chk("pre_rst.addr", imemAddr, 32'h244);
        stall = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("async_rst.cnt", {28'b0, flushCount}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0;
        tick(); chk_all("post_rst", 32'h4, 32'h100, 32'h4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipeline.
- Owns the PC and drives the instruction-memory address.
- Selects the next PC from four sources:
  - the MEM-stage mispredict redirect (jumpSuccess/correctPc from the branch predictor);
  - the ID-stage predicted-taken redirect (mux1select with the ID branch target);
  - a hazard stall;
  - sequential PC+4.
- Produces the ID-stage instruction, pcNew (PC+4) and valid bit; keeps a saturating mispredict-flush counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0000, instruction word injected into IF/ID on reset or flush.
- CNT_W, 16, width of the mispredict-flush counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit hold request; freezes PC and IF/ID.
- jumpSuccess  in  1  mispredict indication from MEM-stage predictor; 1 = redirect required.
- correctPc  in  32  redirect target, valid when jumpSuccess=1.
- mux1select  in  1  ID-stage predicted-taken for the branch currently in ID.
- BpctoID  in  32  branch target computed in ID.
- imemAddr  out  32  instruction memory address (combinational = PC).
- imemData  in  32  instruction word at imemAddr, same cycle (asynchronous read).
- insttoID  out  32  IF/ID instruction.
- pcNewtoID  out  32  IF/ID PC+4 of that instruction.
- validtoID  out  1  IF/ID valid; 0 = bubble.
- flushCount  out  CNT_W  number of mispredict flushes since reset.

Behaviour:
- Reset (asynchronous, takes effect immediately while rst=1):
  - pc=RESET_PC, so imemAddr=RESET_PC.
  - insttoID=NOP, pcNewtoID=0, validtoID=0, flushCount=0.
- First fetch is at RESET_PC on the first rising edge after rst deasserts.
- Per rising edge, fixed priority (highest first):
  1. jumpSuccess=1:
     - pc<=correctPc & ~32'h3.
     - IF/ID <= {NOP, 0, valid 0}.
     - flushCount<=flushCount+1, saturating at all-ones.
     - stall and mux1select are ignored this cycle.
  2. stall=1: pc and IF/ID hold their values; mux1select is ignored, because the branch in ID is itself stalled.
  3. mux1select=1:
     - pc<=BpctoID & ~32'h3.
     - IF/ID <= {NOP, 0, valid 0}; the sequentially fetched wrong-path instruction is squashed.
     - flushCount unchanged.
  4. Otherwise:
     - pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
     - IF/ID <= {imemData, pc+4, valid 1}.
- pc[1:0] is always 00.
- Latency:
  - Redirect asserted in cycle N: the target is on imemAddr in cycle N+1.
  - The target instruction is in IF/ID, valid, in cycle N+2.
  - Exactly one bubble per redirect.
- Back-to-back: jumpSuccess on consecutive cycles redirects each cycle and counts each one.
- Reset mid-operation clears all state regardless of pending redirect or stall.
- No combinational path from any input to insttoID, pcNewtoID or validtoID; imemAddr depends only on pc.

Test Plan:
- Reset then 4 free-run cycles, imem returns addr+0x100 → imemAddr 0,4,8,C; insttoID 0x100,0x104,0x108 with pcNewtoID 4,8,C; validtoID=1 from the first edge.
- At pc=0x10, mux1select=1, BpctoID=0x40 → next imemAddr=0x40; the following IF/ID is a bubble (validtoID=0, insttoID=NOP); then the instruction at 0x40 appears with pcNewtoID=0x44; flushCount stays 0.
- At pc=0x20, jumpSuccess=1, correctPc=0x83, with mux1select=1 and stall=1 in the same cycle → imemAddr=0x80, IF/ID bubble, flushCount=1.
- stall=1 for 3 cycles at pc=0x30 → imemAddr stays 0x30; insttoID, pcNewtoID and validtoID unchanged for all 3 cycles; sequential fetch resumes with 0x34 after stall drops.
- Redirect to 0xFFFF_FFFC then free-run → pc wraps to 0x0; the pcNewtoID of the instruction fetched at 0xFFFF_FFFC is 0x0.
- Force flushCount to all-ones via repeated jumpSuccess (CNT_W=4 build: 17 redirects) → saturates at 0xF; then assert rst mid-stall → all outputs return to reset values asynchronously.
